piso_tx: RTL and testbench

Parallel-in/serial-out transmitter: the sending end of the team's 4-bit SIPO receive shift register. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per enabled cycle. Bit order and framing strobes are chosen so that a SIPO fed from `sout` on the same enabled cycles reassembles the original word. The block sits between the word-level datapath and the serial link. It supports gapless back-to-back words.

---
 rtl/piso_tx.sv | 82 ++++++++
 tb/tb_piso_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load handshake and gapless streaming.
// Frame strobes and bit order line up with a SIPO clocked on sout_valid && shift_en.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             is_last;
    logic             accept;
    logic             next_bit;

    // Any out-of-range count is treated as the last bit so the frame always terminates.
    assign is_last    = (cnt >= LAST);
    assign load_ready = !reset && ((state == IDLE) || (is_last && shift_en));
    assign accept     = load_valid && load_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        if (accept) begin
            sr_n    = load_data;
            cnt_n   = '0;
            state_n = SHIFT;
        end else if (state == SHIFT && shift_en) begin
            if (is_last) begin
                state_n = IDLE;
            end else begin
                sr_n  = LSB_FIRST ? (sr >> 1) : (sr << 1);
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign next_bit = LSB_FIRST ? sr_n[0] : sr_n[WIDTH-1];

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            cnt         <= cnt_n;
            sout        <= (state_n == SHIFT) && next_bit;
            sout_valid  <= (state_n == SHIFT);
            frame_start <= (state_n == SHIFT) && (cnt_n == '0);
            frame_last  <= (state_n == SHIFT) && (cnt_n >= LAST);
            busy        <= (state_n == SHIFT);
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a 4-bit LSB-first instance with a SIPO loopback receiver,
// and an 8-bit MSB-first instance.
module tb_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 4-bit, LSB first
    logic       reset = 1'b1, lv = 1'b0, se = 1'b0;
    logic [3:0] ld = '0;
    logic       ready, sout, sv, fs, fl, busy;

    // 8-bit, MSB first
    logic       reset8 = 1'b1, lv8 = 1'b0, se8 = 1'b0;
    logic [7:0] ld8 = '0;
    logic       ready8, sout8, sv8, fs8, fl8, busy8;

    piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u4 (
        .clk(clk), .reset(reset), .load_valid(lv), .load_ready(ready), .load_data(ld),
        .shift_en(se), .sout(sout), .sout_valid(sv), .frame_start(fs), .frame_last(fl),
        .busy(busy)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u8 (
        .clk(clk), .reset(reset8), .load_valid(lv8), .load_ready(ready8), .load_data(ld8),
        .shift_en(se8), .sout(sout8), .sout_valid(sv8), .frame_start(fs8), .frame_last(fl8),
        .busy(busy8)
    );

    // Receiving SIPO: serial bit enters the MSB and shifts right.
    logic [3:0] q = '0;
    always @(posedge clk) if (sv && se) q <= {sout, q[3:1]};

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({sout, sv, fs, fl, busy, ready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_state: got %b expected 000000", {sout, sv, fs, fl, busy, ready});
        end
        @(negedge clk);
        reset = 1'b0; reset8 = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", ready); end
        // Mid-frame reset: load 1011, reset while bit 2 is on the line.
        lv = 1'b1; ld = 4'b1011; se = 1'b1;
        @(negedge clk); lv = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (sout !== 1'b0 || u4.cnt !== 2'd2) begin
            n_fail++; $display("FAIL pre_reset_bit2: got sout=%b cnt=%0d expected sout=0 cnt=2", sout, u4.cnt);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_reset: got %b expected 0", ready); end
        @(negedge clk); #1;
        n_checks++;
        if ({sout, sv, fs, fl, busy} !== 5'b0) begin
            n_fail++; $display("FAIL midframe_reset: got %b expected 00000", {sout, sv, fs, fl, busy});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_midreset: got %b expected 1", ready); end
        @(negedge clk); #1;
        n_checks++;
        if (sv !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL no_partial_bits: got sv=%b busy=%b expected 0 0", sv, busy);
        end
    endtask

    task automatic test_single();
        logic exp_b[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        lv = 1'b1; ld = 4'b1011; se = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); lv = 1'b0; #1;
            n_checks++;
            if ({sout, sv, fs, fl, busy} !== {exp_b[i], 1'b1, i == 0, i == 3, 1'b1}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got sout/sv/fs/fl/busy=%b expected %b", i,
                         {sout, sv, fs, fl, busy}, {exp_b[i], 1'b1, i == 0, i == 3, 1'b1});
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (sv !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_end: got sv=%b busy=%b expected 0 0", sv, busy);
        end
    endtask

    task automatic test_loopback();
        logic [3:0] words[3] = '{4'hA, 4'h5, 4'hF};
        se = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            lv = 1'b1; ld = words[w];
            @(negedge clk); lv = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            n_checks++;
            if (fl !== 1'b1) begin n_fail++; $display("FAIL loop_last%0d: got fl=%b expected 1", w, fl); end
            @(negedge clk); #1;
            n_checks++;
            if (q !== words[w]) begin
                n_fail++; $display("FAIL loopback%0d: got q=%h expected %h", w, q, words[w]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_b[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        lv = 1'b1; ld = 4'h3; se = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept0: got ready=%b expected 1", ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) ld = 4'hC;
            if (i == 4) lv = 1'b0;
            #1;
            n_checks++;
            if (sout !== exp_b[i] || sv !== 1'b1) begin
                n_fail++; $display("FAIL b2b_bit%0d: got sout=%b sv=%b expected %b 1", i, sout, sv, exp_b[i]);
            end
            if (i < 7) begin
                n_checks++;
                if (ready !== (i == 3)) begin
                    n_fail++; $display("FAIL b2b_ready%0d: got %b expected %b", i, ready, i == 3);
                end
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (sv !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got sv=%b expected 0", sv); end
    endtask

    task automatic test_stall();
        logic pat[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic exp_s[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int   exp_c[7] = '{0, 1, 1, 1, 2, 3, 3};
        logic exp_r[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        lv = 1'b1; ld = 4'b0110; se = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            lv = 1'b0; se = pat[i];
            #1;
            n_checks++;
            if (sout !== exp_s[i] || sv !== 1'b1 || u4.cnt !== 2'(exp_c[i]) || ready !== exp_r[i]) begin
                n_fail++;
                $display("FAIL stall%0d: got sout=%b sv=%b cnt=%0d ready=%b expected %b 1 %0d %b", i,
                         sout, sv, u4.cnt, ready, exp_s[i], exp_c[i], exp_r[i]);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (sv !== 1'b0) begin n_fail++; $display("FAIL stall_end: got sv=%b expected 0", sv); end
    endtask

    task automatic test_msb8();
        @(negedge clk);
        lv8 = 1'b1; ld8 = 8'h81; se8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 7) ld8 = 8'h7E ^ 8'(i);
            else       lv8 = 1'b0;
            #1;
            n_checks++;
            if ({sout8, sv8, fs8, fl8, ready8} !== {(i == 0 || i == 7), 1'b1, i == 0, i == 7, i == 7}) begin
                n_fail++;
                $display("FAIL msb8_bit%0d: got sout/sv/fs/fl/ready=%b expected %b", i,
                         {sout8, sv8, fs8, fl8, ready8}, {(i == 0 || i == 7), 1'b1, i == 0, i == 7, i == 7});
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (sv8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL msb8_end: got sv=%b busy=%b expected 0 0", sv8, busy8);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_stall();
        test_msb8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
